data_ram_ctrl: RTL and testbench

//  Sequences all load/store traffic from the memory stage into the 32-bit word-wide data RAM.

---
 rtl/data_ram_ctrl_pkg.sv | 37 +++
 rtl/data_ram_ctrl_byte_lane.sv | 67 ++++++
 rtl/data_ram_ctrl.sv | 128 ++++++++++++
 tb/tb_data_ram_ctrl.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/data_ram_ctrl_pkg.sv
// Shared definitions for the data RAM controller: funct3 load/store codes,
// FSM state encoding, word/lane constants and the request legality check.
package data_ram_ctrl_pkg;

  localparam int WORD_W = 32;

  localparam logic [2:0] MEM_B  = 3'b000;
  localparam logic [2:0] MEM_H  = 3'b001;
  localparam logic [2:0] MEM_W  = 3'b010;
  localparam logic [2:0] MEM_BU = 3'b100;
  localparam logic [2:0] MEM_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_RDW  = 2'd2,
    ST_WR   = 2'd3
  } state_t;

  // True when a request must be answered with an error instead of a RAM access.
  // Unsigned modes only make sense for loads, so a store with mode[2]=1 is illegal.
  function automatic logic req_illegal(input logic       wr,
                                       input logic [2:0] mode,
                                       input logic [1:0] lane);
    logic bad;
    bad = 1'b0;
    case (mode)
      MEM_B, MEM_BU: bad = 1'b0;
      MEM_H, MEM_HU: bad = lane[0];
      MEM_W:         bad = (lane != 2'b00);
      default:       bad = 1'b1;
    endcase
    if (wr && mode[2]) bad = 1'b1;
    return bad;
  endfunction

endpackage

// File: rtl/data_ram_ctrl_byte_lane.sv
// Combinational lane unit for the data RAM controller.
//  - extract: pulls the addressed byte/half out of a RAM word and sign- or
//    zero-extends it according to funct3.
//  - merge: replaces only the addressed byte/half of a RAM word with the low
//    bits of the store data; all other lanes pass through unchanged.
// Ports:
//  i_word    in   32  word read from RAM
//  i_wdata   in   32  store data (low bits significant)
//  i_mode    in   3   funct3 code
//  i_lane    in   2   byte address [1:0]
//  o_ext     out  32  extended load data
//  o_merged  out  32  read-modify-write result
module data_ram_ctrl_byte_lane
  import data_ram_ctrl_pkg::*;
(
  input  logic [WORD_W-1:0] i_word,
  input  logic [WORD_W-1:0] i_wdata,
  input  logic [2:0]        i_mode,
  input  logic [1:0]        i_lane,
  output logic [WORD_W-1:0] o_ext,
  output logic [WORD_W-1:0] o_merged
);

  logic [4:0]        w_sh_b;
  logic [4:0]        w_sh_h;
  logic [WORD_W-1:0] w_word_b;
  logic [WORD_W-1:0] w_word_h;
  logic [7:0]        w_byte;
  logic [15:0]       w_half;
  logic [WORD_W-1:0] w_mask_b;
  logic [WORD_W-1:0] w_mask_h;
  logic [WORD_W-1:0] w_data_b;
  logic [WORD_W-1:0] w_data_h;

  assign w_sh_b   = {i_lane, 3'b000};
  assign w_sh_h   = {i_lane[1], 4'b0000};
  assign w_word_b = i_word >> w_sh_b;
  assign w_word_h = i_word >> w_sh_h;
  assign w_byte   = w_word_b[7:0];
  assign w_half   = w_word_h[15:0];

  assign w_mask_b = 32'h0000_00FF << w_sh_b;
  assign w_mask_h = 32'h0000_FFFF << w_sh_h;
  assign w_data_b = {24'd0, i_wdata[7:0]} << w_sh_b;
  assign w_data_h = {16'd0, i_wdata[15:0]} << w_sh_h;

  always_comb begin
    o_ext = i_word;
    case (i_mode)
      MEM_B:   o_ext = {{24{w_byte[7]}}, w_byte};
      MEM_BU:  o_ext = {24'd0, w_byte};
      MEM_H:   o_ext = {{16{w_half[15]}}, w_half};
      MEM_HU:  o_ext = {16'd0, w_half};
      default: o_ext = i_word;
    endcase
  end

  always_comb begin
    o_merged = i_wdata;
    case (i_mode)
      MEM_B:   o_merged = (i_word & ~w_mask_b) | w_data_b;
      MEM_H:   o_merged = (i_word & ~w_mask_h) | w_data_h;
      default: o_merged = i_wdata;
    endcase
  end

endmodule

// File: rtl/data_ram_ctrl.sv
// Data RAM controller: sequences all LSU load/store traffic into the
// word-wide data RAM. Loads read a word and extract a lane; sub-word stores
// do read-modify-write; word stores write directly. Sole driver of the RAM.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | ready for a request; also the cycle a response is presented
// ST_RD   | RAM read issued for the latched word address
// ST_RDW  | RAM read data available; extract (load) or merge (store)
// ST_WR   | RAM write issued with the latched or merged word
//
// Ports:
//  i_clk, i_rst        clock, synchronous active-high reset
//  i_req_*/o_req_ready request port (accepted when valid & ready)
//  o_resp_*            one-cycle response pulse with data/error
//  o_ram_*/i_ram_rdata data RAM port, read data one cycle after the read
module data_ram_ctrl
  import data_ram_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_req_valid,
  output logic                  o_req_ready,
  input  logic                  i_req_wr,
  input  logic [2:0]            i_req_mode,
  input  logic [ADDR_WIDTH-1:0] i_req_addr,
  input  logic [DATA_WIDTH-1:0] i_req_wdata,
  output logic                  o_resp_valid,
  output logic [DATA_WIDTH-1:0] o_resp_rdata,
  output logic                  o_resp_err,
  output logic                  o_ram_ena,
  output logic                  o_ram_wr_flag,
  output logic [ADDR_WIDTH-1:0] o_ram_addr,
  output logic [DATA_WIDTH-1:0] o_ram_wdata,
  input  logic [DATA_WIDTH-1:0] i_ram_rdata
);

  state_t                r_state;
  logic                  r_wr;
  logic [2:0]            r_mode;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic                  r_resp_valid;
  logic [DATA_WIDTH-1:0] r_resp_rdata;
  logic                  r_resp_err;

  logic                  w_accept;
  logic [DATA_WIDTH-1:0] w_ext;
  logic [DATA_WIDTH-1:0] w_merged;

  assign w_accept = i_req_valid && (r_state == ST_IDLE);

  data_ram_ctrl_byte_lane u_lane (
    .i_word   (i_ram_rdata),
    .i_wdata  (r_wdata),
    .i_mode   (r_mode),
    .i_lane   (r_addr[1:0]),
    .o_ext    (w_ext),
    .o_merged (w_merged)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= ST_IDLE;
      r_wr         <= 1'b0;
      r_mode       <= 3'b000;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_resp_valid <= 1'b0;
      r_resp_rdata <= '0;
      r_resp_err   <= 1'b0;
    end else begin
      // Response registers default to idle so every response is a single pulse.
      r_resp_valid <= 1'b0;
      r_resp_rdata <= '0;
      r_resp_err   <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_wr    <= i_req_wr;
            r_mode  <= i_req_mode;
            r_addr  <= i_req_addr;
            r_wdata <= i_req_wdata;
            if (req_illegal(i_req_wr, i_req_mode, i_req_addr[1:0])) begin
              r_resp_valid <= 1'b1;
              r_resp_err   <= 1'b1;
            end else if (i_req_wr && (i_req_mode == MEM_W)) begin
              r_state <= ST_WR;
            end else begin
              r_state <= ST_RD;
            end
          end
        end
        ST_RD: r_state <= ST_RDW;
        ST_RDW: begin
          if (r_wr) begin
            // Merged word reuses the store-data register so WR always writes r_wdata.
            r_wdata <= w_merged;
            r_state <= ST_WR;
          end else begin
            r_resp_valid <= 1'b1;
            r_resp_rdata <= w_ext;
            r_state      <= ST_IDLE;
          end
        end
        ST_WR: begin
          r_resp_valid <= 1'b1;
          r_state      <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_req_ready   = (r_state == ST_IDLE);
  assign o_resp_valid  = r_resp_valid;
  assign o_resp_rdata  = r_resp_rdata;
  assign o_resp_err    = r_resp_err;
  // Gated by reset so an in-flight write cannot commit on the reset edge.
  assign o_ram_ena     = ~i_rst && ((r_state == ST_RD) || (r_state == ST_WR));
  assign o_ram_wr_flag = ~i_rst && (r_state == ST_WR);
  assign o_ram_addr    = {r_addr[ADDR_WIDTH-1:2], 2'b00};
  assign o_ram_wdata   = r_wdata;

endmodule

// File: tb/tb_data_ram_ctrl.sv
// Testbench for data_ram_ctrl: a small word RAM model behind the controller,
// a reference memory with load/store semantics, directed cases and a
// randomized request stream.
module tb_data_ram_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_wr;
  logic [2:0]  req_mode;
  logic [15:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        ram_ena;
  logic        ram_wr_flag;
  logic [15:0] ram_addr;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;

  always #5 clk = ~clk;

  data_ram_ctrl #(.ADDR_WIDTH(16), .DATA_WIDTH(32)) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_req_valid   (req_valid),
    .o_req_ready   (req_ready),
    .i_req_wr      (req_wr),
    .i_req_mode    (req_mode),
    .i_req_addr    (req_addr),
    .i_req_wdata   (req_wdata),
    .o_resp_valid  (resp_valid),
    .o_resp_rdata  (resp_rdata),
    .o_resp_err    (resp_err),
    .o_ram_ena     (ram_ena),
    .o_ram_wr_flag (ram_wr_flag),
    .o_ram_addr    (ram_addr),
    .o_ram_wdata   (ram_wdata),
    .i_ram_rdata   (ram_rdata)
  );

  // RAM model: 64 words, synchronous read, preload port for initial contents.
  logic [31:0] ram_mem [0:63];
  logic [31:0] ref_mem [0:63];
  logic        pl_en;
  logic [5:0]  pl_idx;
  logic [31:0] pl_val;

  always @(posedge clk) begin
    if (pl_en) ram_mem[pl_idx] <= pl_val;
    else if (ram_ena) begin
      if (ram_wr_flag) ram_mem[ram_addr[7:2]] <= ram_wdata;
      else ram_rdata <= ram_mem[ram_addr[7:2]];
    end
  end

  int n_cmp = 0;
  int n_mis = 0;
  logic [31:0] last_rdata;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic bit ref_err(bit wr, int mode, int addr);
    case (mode)
      0:       return 0;
      4:       return wr;
      1:       return (addr % 2) != 0;
      5:       return wr || ((addr % 2) != 0);
      2:       return (addr % 4) != 0;
      default: return 1;
    endcase
  endfunction

  function automatic logic [31:0] ref_load(logic [31:0] w, int mode, int addr);
    longint v;
    case (mode)
      0, 4: begin
        v = (w >> (8 * (addr % 4))) & 255;
        if (mode == 0 && v >= 128) v = v - 256;
      end
      1, 5: begin
        v = (w >> (16 * ((addr / 2) % 2))) & 65535;
        if (mode == 1 && v >= 32768) v = v - 65536;
      end
      default: v = w;
    endcase
    return v[31:0];
  endfunction

  function automatic logic [31:0] ref_store(logic [31:0] w, logic [31:0] d, int mode, int addr);
    int sh;
    logic [31:0] m;
    case (mode)
      0: begin sh = 8 * (addr % 4); m = 32'hFF << sh; return (w & ~m) | ((d & 32'hFF) << sh); end
      1: begin sh = 16 * ((addr / 2) % 2); m = 32'hFFFF << sh; return (w & ~m) | ((d & 32'hFFFF) << sh); end
      default: return d;
    endcase
  endfunction

  // Called at a negedge; returns at the negedge of the response cycle, so a
  // following call lands its request on the response cycle (back-to-back).
  task automatic run_req(input bit wr, input logic [2:0] mode, input logic [15:0] addr,
                         input logic [31:0] wdata, input string tag);
    bit          err;
    int          lat, enas_exp, enas, cyc;
    bit          seen;
    logic [31:0] exp_rd;
    int          idx;
    idx    = int'(addr[7:2]);
    err    = ref_err(wr, int'(mode), int'(addr));
    exp_rd = 32'd0;
    if (err) begin lat = 1; enas_exp = 0; end
    else if (!wr) begin lat = 3; enas_exp = 1; exp_rd = ref_load(ref_mem[idx], int'(mode), int'(addr)); end
    else if (mode == 3'b010) begin lat = 2; enas_exp = 1; end
    else begin lat = 4; enas_exp = 2; end
    if (!err && wr) ref_mem[idx] = ref_store(ref_mem[idx], wdata, int'(mode), int'(addr));

    check_eq({tag, " ready"}, {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1; req_wr = wr; req_mode = mode; req_addr = addr; req_wdata = wdata;
    @(posedge clk);
    #1;
    req_valid = 1'b0; req_wr = $urandom_range(0, 1); req_mode = 3'($urandom);
    req_addr = 16'($urandom); req_wdata = $urandom;
    seen = 0; enas = 0; cyc = 0;
    for (int c = 1; c <= 8 && !seen; c++) begin
      @(negedge clk);
      if (ram_ena) begin
        enas++;
        check_eq({tag, " ram_addr"}, {16'd0, ram_addr}, {16'd0, addr[15:2], 2'b00});
      end
      if (resp_valid) begin seen = 1; cyc = c; end
    end
    check_eq({tag, " latency"}, cyc, lat);
    check_eq({tag, " err"}, {31'd0, resp_err}, {31'd0, err});
    check_eq({tag, " rdata"}, resp_rdata, exp_rd);
    check_eq({tag, " ram_ena cycles"}, enas, enas_exp);
    last_rdata = resp_rdata;
  endtask

  initial begin
    int quiet;
    rst = 1'b1; req_valid = 1'b0; req_wr = 1'b0; req_mode = 3'b000;
    req_addr = 16'd0; req_wdata = 32'd0; pl_en = 1'b0; pl_idx = 6'd0; pl_val = 32'd0;

    // Reset, with the RAM preloaded while reset is held.
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      pl_en = 1'b1; pl_idx = 6'(i); pl_val = $urandom; ref_mem[i] = pl_val;
    end
    @(negedge clk);
    pl_en = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("reset resp_valid", {31'd0, resp_valid}, 32'd0);
    check_eq("reset ram_ena", {31'd0, ram_ena}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check_eq("reset ready", {31'd0, req_ready}, 32'd1);
    check_eq("reset rdata", resp_rdata, 32'd0);

    // Word store then load, back-to-back.
    run_req(1, 3'b010, 16'h0010, 32'hDEADBEEF, "sw");
    run_req(0, 3'b010, 16'h0010, 32'd0, "lw");
    check_eq("lw value", last_rdata, 32'hDEADBEEF);

    // Byte store and byte loads.
    run_req(1, 3'b000, 16'h0013, 32'h0000007F, "sb");
    run_req(0, 3'b010, 16'h0010, 32'd0, "lw after sb");
    check_eq("sb merged", last_rdata, 32'h7FADBEEF);
    run_req(0, 3'b000, 16'h0012, 32'd0, "lb");
    check_eq("lb value", last_rdata, 32'hFFFFFFAD);
    run_req(0, 3'b100, 16'h0012, 32'd0, "lbu");
    check_eq("lbu value", last_rdata, 32'h000000AD);

    // Half store and half loads.
    run_req(1, 3'b001, 16'h0012, 32'h00008001, "sh");
    run_req(0, 3'b010, 16'h0010, 32'd0, "lw after sh");
    check_eq("sh merged", last_rdata, 32'h8001BEEF);
    run_req(0, 3'b001, 16'h0012, 32'd0, "lh");
    check_eq("lh value", last_rdata, 32'hFFFF8001);
    run_req(0, 3'b101, 16'h0012, 32'd0, "lhu");
    check_eq("lhu value", last_rdata, 32'h00008001);

    // Error requests.
    run_req(0, 3'b010, 16'h0011, 32'd0, "err lw misaligned");
    run_req(1, 3'b001, 16'h0013, 32'h1234, "err sh misaligned");
    run_req(0, 3'b011, 16'h0010, 32'd0, "err mode 011");
    run_req(1, 3'b100, 16'h0010, 32'h55, "err store unsigned");

    // Reset during the write phase of a byte store.
    req_valid = 1'b1; req_wr = 1'b1; req_mode = 3'b000; req_addr = 16'h0010; req_wdata = 32'h11;
    @(posedge clk);
    #1 req_valid = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst-in-wr write phase", {31'd0, ram_wr_flag}, 32'd1);
    rst = 1'b1;
    #1;
    check_eq("rst-in-wr ram_ena gated", {31'd0, ram_ena}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    quiet = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (resp_valid) quiet++;
    end
    check_eq("rst-in-wr no response", quiet, 0);
    run_req(0, 3'b010, 16'h0010, 32'd0, "lw after abort");
    check_eq("abort kept word", last_rdata, 32'h8001BEEF);

    // Back-to-back store/load on another word.
    run_req(1, 3'b010, 16'h0020, 32'hCAFEF00D, "b2b sw");
    run_req(0, 3'b010, 16'h0020, 32'd0, "b2b lw");
    check_eq("b2b value", last_rdata, 32'hCAFEF00D);

    // Randomized stream.
    for (int n = 0; n < 300; n++) begin
      logic [2:0]  m;
      logic [15:0] a;
      bit          w;
      int          lane;
      case ($urandom_range(0, 9))
        0, 1:    m = 3'b000;
        2, 3:    m = 3'b001;
        4, 5:    m = 3'b010;
        6:       m = 3'b100;
        7:       m = 3'b101;
        8:       m = 3'b011;
        default: m = ($urandom_range(0, 1) != 0) ? 3'b110 : 3'b111;
      endcase
      w = $urandom_range(0, 1);
      lane = $urandom_range(0, 3);
      if ($urandom_range(0, 3) != 0) begin
        if (m == 3'b010) lane = 0;
        else if (m == 3'b001 || m == 3'b101) lane = lane & 2;
      end
      a = {8'd0, 6'($urandom_range(0, 63)), 2'(lane)};
      run_req(w, m, a, $urandom, "rand");
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    // RAM contents must match the reference memory word for word.
    for (int i = 0; i < 64; i++) check_eq("final mem", ram_mem[i], ref_mem[i]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
